// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/D memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        s_arb_idle,
        s_arb_access,
        s_arb_resp
    } s_arb;

    typedef enum logic {
        owner_if,
        owner_d
    } arb_owner;

    localparam logic [3:0] WE_NONE = 4'b0000;

    // Wide enough for RD_LAT-1 with RD_LAT up to 7.
    localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin picker. o_gnt[0] = IF, o_gnt[1] = D.
// On a tie the requester that did not win last time is chosen.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_d_req,
    input  arb_owner   i_last_owner,
    output logic [1:0] o_gnt
);

    // Pick at most one requester, alternating on ties.
    always_comb begin
        o_gnt = '0;
        if (i_if_req && i_d_req) begin
            if (i_last_owner == owner_if) begin
                o_gnt = 2'b10;
            end else begin
                o_gnt = 2'b01;
            end
        end else if (i_if_req) begin
            o_gnt = 2'b01;
        end else if (i_d_req) begin
            o_gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported BRAM between the instruction-fetch
// requester (IF) and the load/store requester (D). One transaction is
// outstanding at a time; responses are routed back to the owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(RD_LAT - 1);

    s_arb              r_state;
    s_arb              w_state_nxt;
    arb_owner          r_owner;
    arb_owner          r_last_owner;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_is_wr;
    logic              r_mem_en;
    logic [3:0]        r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;

    logic [1:0]        w_pick;
    logic              w_idle;
    logic              w_if_gnt;
    logic              w_d_gnt;

    rr_pick u_rr_pick (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_pick)
    );

    assign w_idle   = (r_state == s_arb_idle);
    assign w_if_gnt = w_idle & w_pick[0];
    assign w_d_gnt  = w_idle & w_pick[1];

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= s_arb_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: grant -> access -> wait latency -> idle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            s_arb_idle: begin
                if (w_if_gnt || w_d_gnt) begin
                    w_state_nxt = s_arb_access;
                end
            end
            s_arb_access: begin
                w_state_nxt = s_arb_resp;
            end
            s_arb_resp: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = s_arb_idle;
                end
            end
            default: begin
                w_state_nxt = s_arb_idle;
            end
        endcase
    end

    // Memory command registers, latency counter and response routing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_owner      <= owner_if;
            r_last_owner <= owner_if;
            r_lat_cnt    <= '0;
            r_is_wr      <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= WE_NONE;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            unique case (r_state)
                s_arb_idle: begin
                    if (w_d_gnt) begin
                        r_owner      <= owner_d;
                        r_last_owner <= owner_d;
                        r_mem_en     <= 1'b1;
                        r_mem_addr   <= d_addr;
                        r_mem_we     <= d_we;
                        r_mem_din    <= d_wdata;
                        r_is_wr      <= (d_we != WE_NONE);
                    end else if (w_if_gnt) begin
                        r_owner      <= owner_if;
                        r_last_owner <= owner_if;
                        r_mem_en     <= 1'b1;
                        r_mem_addr   <= if_addr;
                        r_mem_we     <= WE_NONE;
                        r_mem_din    <= '0;
                        r_is_wr      <= 1'b0;
                    end
                end
                s_arb_access: begin
                    r_mem_en  <= 1'b0;
                    r_mem_we  <= WE_NONE;
                    r_lat_cnt <= r_is_wr ? '0 : LAT_RELOAD;
                end
                s_arb_resp: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end else if (r_owner == owner_d) begin
                        r_d_rdata  <= r_is_wr ? '0 : mem_dout;
                        r_d_rvalid <= 1'b1;
                    end else begin
                        r_if_rdata  <= mem_dout;
                        r_if_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= WE_NONE;
                end
            endcase
        end
    end

endmodule
